io_page_decoder: RTL and testbench
==================================

Name: io_page_decoder

Overview:
CPU-side IO page decoder and read-data return stage in the femtosoc memory map. It sits directly upstream of every memory-mapped IO device, including the hardware-config constants block, UART and mapped SPI flash. It decodes one-hot word-address bits into per-device selects and issues single-cycle read and write strobes. It collects device read data into a registered return word and drives the CPU's rbusy/wbusy stalls, with a busy timeout and sticky error flags.

Parameters:
N_DEV, 16, number of one-hot device slots; address bits [N_DEV+1:2].
IO_PAGE_BIT, 22, address bit that selects the IO page.
TIMEOUT, 255, maximum cycles a device may hold busy before abort (8-bit counter).
ERR_DATA, 32'h0, read data returned on decode error or timeout.

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous assert, active-low
mem_addr  in  32  CPU byte address
mem_wdata  in  32  CPU write data
mem_wmask  in  4  CPU byte-write mask; nonzero means write request
mem_rstrb  in  1  CPU read strobe
mem_rdata  out  32  registered IO read data
mem_rbusy  out  1  CPU read stall
mem_wbusy  out  1  CPU write stall
io_sel  out  N_DEV  latched one-hot device select
io_rstrb  out  1  one-cycle device read strobe
io_wstrb  out  1  one-cycle device write strobe
io_wdata  out  32  latched write data
io_wmask  out  4  latched write mask
io_rdata  in  32*N_DEV  packed device read data; slot k is bits [32k+31:32k]
io_rbusy  in  N_DEV  per-device read busy
io_wbusy  in  N_DEV  per-device write busy
err_clr  in  1  clears sticky errors
err_decode  out  1  sticky: non-one-hot IO address accessed
err_timeout  out  1  sticky: device busy exceeded TIMEOUT

Behaviour:
- Reset (resetn=0, async): state IDLE. All outputs 0; timeout counter 0.
- Request detection:
  - io_req = mem_addr[IO_PAGE_BIT].
  - rd_req = io_req & mem_rstrb.
  - wr_req = io_req & |mem_wmask.
  - Accesses outside the IO page are ignored; busy outputs stay 0.
- Decode: oh = mem_addr[N_DEV+1:2]. The address is valid iff exactly one bit is set; idx is the encoded position.
- States: IDLE, RD_WAIT, WR_WAIT, ERR_RET.
- IDLE:
  - In cycle T with rd_req or wr_req: mem_rbusy/mem_wbusy assert combinationally in T, matching the request type.
  - If wr_req and rd_req occur together, the write wins and the read is dropped.
  - Valid address: latch io_sel=oh, io_wdata, io_wmask; go to RD_WAIT or WR_WAIT. io_rstrb or io_wstrb pulses high for exactly cycle T+1.
  - Invalid address: set err_decode; no strobes; go to ERR_RET.
- RD_WAIT:
  - Each cycle, if io_rbusy[idx]==0: capture io_rdata slot idx into mem_rdata, clear io_sel, go to IDLE.
  - mem_rbusy stays high through the capture cycle and is low from the next cycle. Minimum latency: data is valid and rbusy is low at T+2.
- WR_WAIT: same as RD_WAIT, using io_wbusy[idx]; mem_rdata is unchanged.
- ERR_RET: load mem_rdata=ERR_DATA on reads; drop busy; go to IDLE. Busy is therefore low at T+2.
- Timeout:
  - The counter clears on entry to RD_WAIT/WR_WAIT and increments each busy cycle.
  - When it reaches TIMEOUT: abort, set err_timeout, clear io_sel, go to IDLE. Reads return ERR_DATA.
  - Busy for exactly TIMEOUT-1 cycles completes normally.
- New requests in non-IDLE states are ignored (the CPU is stalled).
- err_clr clears both sticky flags. If a flag is set in the same cycle as err_clr, the set wins.
- Reset mid-operation: immediate return to IDLE; the in-flight strobe is not re-issued and the device sees a truncated access.
- io_rdata from unselected slots is never observed, so devices need not zero their outputs.

Decomposition:
- Shared package io_map_pkg:
  - IO_PAGE_BIT.
  - Device bit indices: UART_DAT, UART_CNTL, MAPPED_SPI_FLASH, HWCFG_MEMORY, HWCFG_DEVICES, HWCFG_CPUINFO.
  - State enum and ERR_DATA.
- One sub-module, io_onehot_encode: combinational; oh -> (valid, idx). Reused by the device-config bitmap logic.

Test Plan:
- Read with idx=3, io_rdata slot3=32'h1234_5678, rbusy=0: io_rstrb at T+1, io_sel=16'h0008; mem_rdata=32'h12345678 and rbusy low at T+2.
- Write to slot 0 with wmask=4'b0011, wdata=32'hA5: io_wstrb at T+1 with wmask=0011; device holds wbusy 5 cycles; mem_wbusy drops the cycle after wbusy falls.
- Read at addr with oh=16'h0006: no strobe, err_decode=1, mem_rdata=0 at T+2. Then err_clr clears the flag.
- Device holds rbusy forever: abort after 255 busy cycles, err_timeout=1, mem_rdata=0. With rbusy held 254 cycles instead, completes normally with no error.
- Non-IO address (bit22=0) read/write: no strobes, no busy, no flag changes.
- resetn pulsed low in RD_WAIT: all outputs 0 immediately; the next request is serviced normally.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared femtosoc IO map definitions: page bit, device slot indices,
// decoder state type and the data word returned on aborted reads.
package io_map_pkg;

  localparam int unsigned IO_PAGE_BIT = 22;

  localparam int unsigned UART_DAT         = 4;
  localparam int unsigned UART_CNTL        = 5;
  localparam int unsigned MAPPED_SPI_FLASH = 12;
  localparam int unsigned HWCFG_MEMORY     = 13;
  localparam int unsigned HWCFG_DEVICES    = 14;
  localparam int unsigned HWCFG_CPUINFO    = 15;

  localparam logic [31:0] ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    ERR_RET
  } io_state_e;

  // Byte address of the IO word whose one-hot select bit is dev_bit.
  function automatic logic [31:0] io_word_addr(input int unsigned dev_bit);
    return (32'd1 << IO_PAGE_BIT) | (32'd1 << (dev_bit + 2));
  endfunction

endpackage

// File: rtl/io_page_decoder_if.sv
// CPU-side memory bus and device-side IO bus seen by the IO page decoder.
interface io_page_decoder_if #(
  parameter int unsigned N_DEV = 16
);

  logic [31:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_wmask;
  logic                mem_rstrb;
  logic [31:0]         mem_rdata;
  logic                mem_rbusy;
  logic                mem_wbusy;

  logic [N_DEV-1:0]    io_sel;
  logic                io_rstrb;
  logic                io_wstrb;
  logic [31:0]         io_wdata;
  logic [3:0]          io_wmask;
  logic [32*N_DEV-1:0] io_rdata;
  logic [N_DEV-1:0]    io_rbusy;
  logic [N_DEV-1:0]    io_wbusy;

  // Decoder view.
  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata, mem_rbusy, mem_wbusy,
    output io_sel, io_rstrb, io_wstrb, io_wdata, io_wmask,
    input  io_rdata, io_rbusy, io_wbusy
  );

  // CPU plus devices view.
  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata, mem_rbusy, mem_wbusy,
    input  io_sel, io_rstrb, io_wstrb, io_wdata, io_wmask,
    output io_rdata, io_rbusy, io_wbusy
  );

endinterface

// File: rtl/io_onehot_encode.sv
// One-hot to binary encoder with an exactly-one-bit-set validity flag.
module io_onehot_encode #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_oh,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_oh[i]) o_idx = o_idx | IDX_W'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit word.
  assign o_valid = (i_oh != '0) && ((i_oh & (i_oh - N'(1))) == '0);

endmodule

// File: rtl/io_page_decoder.sv
// IO page decoder: one-hot device select, single-cycle device strobes,
// registered read return, CPU stalls, busy timeout and sticky error flags.
module io_page_decoder
  import io_map_pkg::*;
#(
  parameter int unsigned N_DEV       = 16,
  parameter int unsigned IO_PAGE_BIT = io_map_pkg::IO_PAGE_BIT,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = io_map_pkg::ERR_DATA
) (
  input  logic                   clk,
  input  logic                   resetn,
  io_page_decoder_if.slave       bus,
  input  logic                   err_clr,
  output logic                   err_decode,
  output logic                   err_timeout
);

  localparam int unsigned IDX_W   = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  logic             w_io_req;
  logic             w_rd_req;
  logic             w_wr_req;
  logic [N_DEV-1:0] w_oh;
  logic             w_valid;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_slot_rdata;
  logic             w_slot_rbusy;
  logic             w_slot_wbusy;
  logic             w_slot_busy;
  logic             w_rbusy;
  logic             w_wbusy;
  logic             w_unused;

  io_state_e        r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_is_rd;
  logic [7:0]       r_cnt;
  logic [31:0]      r_rdata;
  logic [N_DEV-1:0] r_sel;
  logic             r_rstrb;
  logic             r_wstrb;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wmask;
  logic             r_err_decode;
  logic             r_err_timeout;

  assign w_io_req = bus.mem_addr[IO_PAGE_BIT];
  assign w_rd_req = w_io_req & bus.mem_rstrb;
  assign w_wr_req = w_io_req & (|bus.mem_wmask);
  assign w_oh     = bus.mem_addr[N_DEV+1:2];
  assign w_unused = ^bus.mem_addr;

  io_onehot_encode #(
    .N     (N_DEV),
    .IDX_W (IDX_W)
  ) u_encode (
    .i_oh    (w_oh),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  // Only the latched slot is ever looked at; other slots may carry anything.
  always_comb begin
    w_slot_rdata = '0;
    w_slot_rbusy = 1'b0;
    w_slot_wbusy = 1'b0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_slot_rdata = bus.io_rdata[32*i +: 32];
        w_slot_rbusy = bus.io_rbusy[i];
        w_slot_wbusy = bus.io_wbusy[i];
      end
    end
  end

  assign w_slot_busy = (r_state == RD_WAIT) ? w_slot_rbusy : w_slot_wbusy;

  always_comb begin
    w_rbusy = 1'b0;
    w_wbusy = 1'b0;
    case (r_state)
      IDLE: begin
        w_wbusy = w_wr_req;
        w_rbusy = w_rd_req & ~w_wr_req;
      end
      RD_WAIT: w_rbusy = 1'b1;
      WR_WAIT: w_wbusy = 1'b1;
      ERR_RET: begin
        w_rbusy = r_is_rd;
        w_wbusy = ~r_is_rd;
      end
      default: begin
        w_rbusy = 1'b0;
        w_wbusy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_is_rd       <= 1'b0;
      r_cnt         <= '0;
      r_rdata       <= '0;
      r_sel         <= '0;
      r_rstrb       <= 1'b0;
      r_wstrb       <= 1'b0;
      r_wdata       <= '0;
      r_wmask       <= '0;
      r_err_decode  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_rstrb <= 1'b0;
      r_wstrb <= 1'b0;
      // Flag sets below are later in the block, so a set beats a clear.
      if (err_clr) begin
        r_err_decode  <= 1'b0;
        r_err_timeout <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_rd_req || w_wr_req) begin
            r_is_rd <= ~w_wr_req;
            if (w_valid) begin
              r_sel   <= w_oh;
              r_idx   <= w_idx;
              r_wdata <= bus.mem_wdata;
              r_wmask <= bus.mem_wmask;
              r_cnt   <= '0;
              if (w_wr_req) begin
                r_wstrb <= 1'b1;
                r_state <= WR_WAIT;
              end else begin
                r_rstrb <= 1'b1;
                r_state <= RD_WAIT;
              end
            end else begin
              r_err_decode <= 1'b1;
              r_state      <= ERR_RET;
            end
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (!w_slot_busy) begin
            if (r_state == RD_WAIT) r_rdata <= w_slot_rdata;
            r_sel   <= '0;
            r_state <= IDLE;
          end else if (r_cnt == TO_LAST) begin
            if (r_state == RD_WAIT) r_rdata <= ERR_DATA;
            r_err_timeout <= 1'b1;
            r_sel         <= '0;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ERR_RET: begin
          if (r_is_rd) r_rdata <= ERR_DATA;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rdata = r_rdata;
  assign bus.mem_rbusy = w_rbusy;
  assign bus.mem_wbusy = w_wbusy;
  assign bus.io_sel    = r_sel;
  assign bus.io_rstrb  = r_rstrb;
  assign bus.io_wstrb  = r_wstrb;
  assign bus.io_wdata  = r_wdata;
  assign bus.io_wmask  = r_wmask;
  assign err_decode    = r_err_decode;
  assign err_timeout   = r_err_timeout;

  a_strobe_excl : assert property (@(posedge clk) disable iff (!resetn)
    !(r_rstrb && r_wstrb));
  a_sel_onehot0 : assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(r_sel));
  a_strobe_sel  : assert property (@(posedge clk) disable iff (!resetn)
    (r_rstrb || r_wstrb) |-> (r_sel != '0));

endmodule

// File: tb/tb_io_page_decoder.sv
// Randomized bench for io_page_decoder with a transaction-level reference
// model and a simple latency-programmable device model.
module tb_io_page_decoder;
  import io_map_pkg::*;

  localparam int unsigned N_DEV   = 16;
  localparam int          TIMEOUT = 255;

  logic clk = 1'b0;
  logic resetn;
  logic err_clr;
  logic err_decode;
  logic err_timeout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  io_page_decoder_if #(.N_DEV(N_DEV)) bus ();

  io_page_decoder #(
    .N_DEV       (N_DEV),
    .IO_PAGE_BIT (IO_PAGE_BIT),
    .TIMEOUT     (TIMEOUT),
    .ERR_DATA    (ERR_DATA)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .err_clr     (err_clr),
    .err_decode  (err_decode),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Device model: busy for dev_lat cycles starting with the strobe cycle;
  // dev_lat < 0 means busy forever.
  int               dev_lat;
  int               rem;
  logic             cur_rd;
  logic             busy_now;
  logic [N_DEV-1:0] junk_rb, junk_wb;
  logic [31:0]      slots [N_DEV];

  always_comb begin
    if (bus.io_rstrb || bus.io_wstrb) busy_now = (dev_lat != 0);
    else                              busy_now = (rem != 0);
    bus.io_rbusy = (junk_rb & ~bus.io_sel) | ((cur_rd ? busy_now : 1'b1) ? bus.io_sel : '0);
    bus.io_wbusy = (junk_wb & ~bus.io_sel) | ((cur_rd ? 1'b1 : busy_now) ? bus.io_sel : '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn)                          rem <= 0;
    else if (bus.io_rstrb || bus.io_wstrb) rem <= (dev_lat < 0) ? -1 : ((dev_lat > 0) ? dev_lat - 1 : 0);
    else if (rem > 0)                     rem <= rem - 1;
  end

  logic [31:0] exp_rdata;
  logic        exp_dec, exp_to;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic fill_slots();
    for (int k = 0; k < int'(N_DEV); k++) begin
      slots[k] = $urandom;
      bus.io_rdata[32*k +: 32] = slots[k];
    end
    junk_rb = N_DEV'($urandom);
    junk_wb = N_DEV'($urandom);
  endtask

  function automatic logic [31:0] make_addr(input logic io, input logic [N_DEV-1:0] oh);
    logic [31:0] a;
    a = $urandom;
    a[N_DEV+1:2] = oh;
    a[IO_PAGE_BIT] = io;
    return a;
  endfunction

  task automatic run_txn(input string nm, input logic [31:0] addr, input logic rd,
                         input logic [3:0] wmask, input logic [31:0] wdata,
                         input int lat, input logic clr);
    logic [N_DEV-1:0] oh;
    logic io, wr, rdq, valid, req;
    int idx, done, last;
    io    = addr[IO_PAGE_BIT];
    wr    = io && (wmask != 4'd0);
    rdq   = io && rd && !wr;
    req   = wr || rdq;
    oh    = addr[N_DEV+1:2];
    valid = ($countones(oh) == 1);
    idx   = 0;
    for (int k = 0; k < int'(N_DEV); k++) if (oh[k]) idx = k;
    dev_lat = lat;
    cur_rd  = rdq;

    if (clr) begin exp_dec = 1'b0; exp_to = 1'b0; end
    if (!req) done = 0;
    else if (!valid) begin
      done = 2; exp_dec = 1'b1;
      if (rdq) exp_rdata = ERR_DATA;
    end else if (lat < 0 || lat >= TIMEOUT) begin
      done = 1 + TIMEOUT; exp_to = 1'b1;
      if (rdq) exp_rdata = ERR_DATA;
    end else begin
      done = 2 + lat;
      if (rdq) exp_rdata = slots[idx];
    end

    @(negedge clk);
    bus.mem_addr  = addr;
    bus.mem_rstrb = rd;
    bus.mem_wmask = wmask;
    bus.mem_wdata = wdata;
    err_clr       = clr;
    #1;
    check({nm, ".rbusy_T"}, 64'(bus.mem_rbusy), 64'(rdq));
    check({nm, ".wbusy_T"}, 64'(bus.mem_wbusy), 64'(wr));

    @(negedge clk);
    bus.mem_rstrb = 1'b0;
    bus.mem_wmask = 4'd0;
    bus.mem_addr  = $urandom & ~(32'd1 << IO_PAGE_BIT);
    bus.mem_wdata = $urandom;
    err_clr       = 1'b0;
    #1;
    check({nm, ".rstrb_T1"}, 64'(bus.io_rstrb), 64'(rdq && valid));
    check({nm, ".wstrb_T1"}, 64'(bus.io_wstrb), 64'(wr && valid));
    check({nm, ".rbusy_T1"}, 64'(bus.mem_rbusy), 64'(rdq));
    check({nm, ".wbusy_T1"}, 64'(bus.mem_wbusy), 64'(wr));
    if (req && valid) begin
      check({nm, ".sel_T1"},   64'(bus.io_sel),   64'(oh));
      check({nm, ".wmask_T1"}, 64'(bus.io_wmask), 64'(wmask));
      check({nm, ".wdata_T1"}, 64'(bus.io_wdata), 64'(wdata));
    end else begin
      check({nm, ".sel_T1"}, 64'(bus.io_sel), 64'd0);
    end

    last = (done > 2) ? done : 2;
    for (int k = 2; k <= last; k++) begin
      @(negedge clk);
      #1;
      check({nm, ".rbusy"}, 64'(bus.mem_rbusy), 64'(rdq && (k < done)));
      check({nm, ".wbusy"}, 64'(bus.mem_wbusy), 64'(wr && (k < done)));
      if (k == 2) check({nm, ".strb_T2"}, 64'({bus.io_rstrb, bus.io_wstrb}), 64'd0);
    end
    check({nm, ".rdata"},   64'(bus.mem_rdata), 64'(exp_rdata));
    check({nm, ".err_dec"}, 64'(err_decode),    64'(exp_dec));
    check({nm, ".err_to"},  64'(err_timeout),   64'(exp_to));
    check({nm, ".sel_end"}, 64'(bus.io_sel),    64'd0);
  endtask

  task automatic pulse_clr(input string nm);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_dec = 1'b0;
    exp_to  = 1'b0;
    #1;
    check({nm, ".err_dec"}, 64'(err_decode),  64'd0);
    check({nm, ".err_to"},  64'(err_timeout), 64'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".rdata"}, 64'(bus.mem_rdata), 64'd0);
    check({nm, ".busy"},  64'({bus.mem_rbusy, bus.mem_wbusy}), 64'd0);
    check({nm, ".sel"},   64'(bus.io_sel), 64'd0);
    check({nm, ".strb"},  64'({bus.io_rstrb, bus.io_wstrb}), 64'd0);
    check({nm, ".wdata"}, 64'(bus.io_wdata), 64'd0);
    check({nm, ".wmask"}, 64'(bus.io_wmask), 64'd0);
    check({nm, ".errs"},  64'({err_decode, err_timeout}), 64'd0);
  endtask

  initial begin
    logic [N_DEV-1:0] oh;
    logic [31:0]      a;
    resetn        = 1'b0;
    err_clr       = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.mem_rstrb = 1'b0;
    dev_lat       = 0;
    cur_rd        = 1'b0;
    exp_rdata     = '0;
    exp_dec       = 1'b0;
    exp_to        = 1'b0;
    fill_slots();

    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;

    fill_slots();
    slots[3] = 32'h1234_5678;
    bus.io_rdata[32*3 +: 32] = slots[3];
    run_txn("rd3", io_word_addr(3), 1'b1, 4'd0, $urandom, 0, 1'b0);
    run_txn("wr0", io_word_addr(0), 1'b0, 4'b0011, 32'hA5, 5, 1'b0);
    run_txn("bad6", make_addr(1'b1, 16'h0006), 1'b1, 4'd0, $urandom, 0, 1'b0);
    pulse_clr("clr1");
    run_txn("bad0", make_addr(1'b1, 16'h0000), 1'b0, 4'b1000, $urandom, 0, 1'b0);

    fill_slots();
    run_txn("to_rd", io_word_addr(UART_DAT), 1'b1, 4'd0, $urandom, -1, 1'b0);
    fill_slots();
    run_txn("rd254", io_word_addr(HWCFG_CPUINFO), 1'b1, 4'd0, $urandom, TIMEOUT - 1, 1'b0);
    run_txn("to_wr", io_word_addr(UART_CNTL), 1'b0, 4'b1111, $urandom, -1, 1'b0);
    run_txn("clr_set", make_addr(1'b1, 16'h0300), 1'b1, 4'd0, $urandom, 0, 1'b1);

    run_txn("nio_rd", make_addr(1'b0, 16'h0010), 1'b1, 4'd0, $urandom, 0, 1'b0);
    run_txn("nio_wr", make_addr(1'b0, 16'h0004), 1'b0, 4'b0101, $urandom, 0, 1'b0);
    run_txn("rw_both", io_word_addr(MAPPED_SPI_FLASH), 1'b1, 4'b0110, $urandom, 2, 1'b0);

    for (int n = 0; n < 60; n++) begin
      fill_slots();
      if ($urandom_range(3) != 0) oh = N_DEV'(1) << $urandom_range(N_DEV - 1);
      else                        oh = N_DEV'($urandom);
      a = make_addr(($urandom_range(4) != 0), oh);
      run_txn("rnd", a, 1'($urandom), ($urandom_range(1) != 0) ? 4'($urandom) : 4'd0,
              $urandom, int'($urandom_range(6)), ($urandom_range(9) == 0));
    end

    // Reset while a read is stuck in the wait state.
    fill_slots();
    dev_lat = -1;
    cur_rd  = 1'b1;
    @(negedge clk);
    bus.mem_addr  = io_word_addr(HWCFG_MEMORY);
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.mem_rstrb = 1'b1;
    @(negedge clk);
    bus.mem_rstrb = 1'b0;
    bus.mem_addr  = '0;
    @(negedge clk);
    #1;
    check("mid.rbusy", 64'(bus.mem_rbusy), 64'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    resetn    = 1'b1;
    exp_rdata = '0;
    exp_dec   = 1'b0;
    exp_to    = 1'b0;
    fill_slots();
    run_txn("post_rst", io_word_addr(7), 1'b1, 4'd0, $urandom, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
